// File: rtl/chess_input_conditioner_pkg.sv
// Shared constants for the chess-timer button front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chess_input_conditioner_pkg;

    // 10 ms of stability at a 50 MHz core clock.
    localparam int DEBOUNCE_10MS_50MHZ = 500000;

    // Player index carried on o_last_turn and used to select request bits.
    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

endpackage

// File: rtl/chess_input_conditioner_debounce_channel.sv
// Purpose: one button channel: 2-flop synchroniser, stability counter, edge strobes.
// Latency: o_level moves DEBOUNCE_CYCLES+2 edges after i_raw changes; strobes lead that edge by one cycle.
// Backpressure: none; free-running, every cycle is consumed.
//
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_raw           asynchronous raw level
//   o_level         debounced level (registered)
//   o_press         combinational strobe, high in the cycle whose closing edge commits 0->1
//   o_release       combinational strobe, high in the cycle whose closing edge commits 1->0
module debounce_channel
    import chess_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int CNT_W           = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    logic w_mismatch;
    logic w_commit;

    assign w_mismatch = (r_s2 != r_stable);
    // The counter only advances while mismatched and is cleared on commit,
    // so it never exceeds CNT_LAST and cannot wrap.
    assign w_commit   = w_mismatch && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_commit) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level   = r_stable;
    // Strobes are exposed one cycle early so the parent can register them
    // together with its arbitration decision on the commit edge.
    assign o_press   = w_commit && !r_stable;
    assign o_release = w_commit &&  r_stable;

endmodule

// File: rtl/chess_input_conditioner.sv
// Purpose: debounced, edge-detected turn buttons plus turn-end arbitration for the chess-timer FSM.
// Latency: o_level/o_press/o_release/o_turn_req/o_conflict all update DEBOUNCE_CYCLES+2 edges after i_raw changes.
// Backpressure: none; masked (i_enable=0) presses are dropped, never queued.
//
// Ports:
//   i_clk, i_reset  50 MHz clock, synchronous active-high reset
//   i_enable        1 = turn requests may be issued
//   i_raw           raw button levels, bit p = player p
//   o_level         debounced levels
//   o_press         1-cycle pulse on debounced 0->1
//   o_release       1-cycle pulse on debounced 1->0
//   o_turn_req      one-hot-or-zero 1-cycle turn-end request
//   o_conflict      1-cycle pulse when both players press in the same cycle
//   o_last_turn     index of the last granted player
module chess_input_conditioner
    import chess_input_conditioner_pkg::*;
#(
    // Arbitration below is written for exactly two players.
    parameter int N_INPUTS        = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int CNT_W           = 20
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [N_INPUTS-1:0] i_raw,
    output logic [N_INPUTS-1:0] o_level,
    output logic [N_INPUTS-1:0] o_press,
    output logic [N_INPUTS-1:0] o_release,
    output logic [N_INPUTS-1:0] o_turn_req,
    output logic                o_conflict,
    output logic                o_last_turn
);

    logic [N_INPUTS-1:0] w_press_nxt;
    logic [N_INPUTS-1:0] w_release_nxt;
    logic [N_INPUTS-1:0] w_grant;
    logic                w_conflict;

    logic [N_INPUTS-1:0] r_press;
    logic [N_INPUTS-1:0] r_release;
    logic [N_INPUTS-1:0] r_turn_req;
    logic                r_conflict;
    logic                r_last_turn;
    logic                r_any_granted;

    for (genvar p = 0; p < N_INPUTS; p++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_raw     (i_raw[p]),
            .o_level   (o_level[p]),
            .o_press   (w_press_nxt[p]),
            .o_release (w_release_nxt[p])
        );
    end

    // A player may not end the turn twice in a row; the very first grant
    // after reset is open to either player.
    always_comb begin
        w_conflict = 1'b0;
        w_grant    = '0;
        if (i_enable) begin
            if (w_press_nxt[PLAYER_1] && w_press_nxt[PLAYER_2]) begin
                w_conflict = 1'b1;
            end else if (w_press_nxt[PLAYER_1]) begin
                if (!r_any_granted || (r_last_turn != PLAYER_1)) begin
                    w_grant[PLAYER_1] = 1'b1;
                end
            end else if (w_press_nxt[PLAYER_2]) begin
                if (!r_any_granted || (r_last_turn != PLAYER_2)) begin
                    w_grant[PLAYER_2] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_press       <= '0;
            r_release     <= '0;
            r_turn_req    <= '0;
            r_conflict    <= 1'b0;
            r_last_turn   <= PLAYER_1;
            r_any_granted <= 1'b0;
        end else begin
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_turn_req <= w_grant;
            r_conflict <= w_conflict;
            if (|w_grant) begin
                r_last_turn   <= w_grant[PLAYER_2] ? PLAYER_2 : PLAYER_1;
                r_any_granted <= 1'b1;
            end
        end
    end

    assign o_press     = r_press;
    assign o_release   = r_release;
    assign o_turn_req  = r_turn_req;
    assign o_conflict  = r_conflict;
    assign o_last_turn = r_last_turn;

endmodule

// File: tb/tb_chess_input_conditioner.sv
module tb_chess_input_conditioner;

    localparam int D     = 4;
    localparam int CNT_W = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] raw;
    logic [1:0] o_level, o_press, o_release, o_turn_req;
    logic       o_conflict, o_last_turn;

    always #5 clk = ~clk;

    chess_input_conditioner #(
        .N_INPUTS        (2),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_raw       (raw),
        .o_level     (o_level),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_turn_req  (o_turn_req),
        .o_conflict  (o_conflict),
        .o_last_turn (o_last_turn)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a change is accepted when the last D synchronised
    // samples all differ from the accepted level.
    bit         m_hist [2][D+1];   // [0] = newest raw sample since reset
    int         m_valid [2];
    bit         m_stable [2];
    bit         m_any;
    logic [1:0] e_level, e_press, e_release, e_req;
    logic       e_conf, e_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [1:0] r, input logic rs, input logic en_i);
        e_press   = '0;
        e_release = '0;
        e_req     = '0;
        e_conf    = 1'b0;
        if (rs) begin
            for (int p = 0; p < 2; p++) begin
                m_valid[p]  = 0;
                m_stable[p] = 1'b0;
                for (int k = 0; k <= D; k++) m_hist[p][k] = 1'b0;
            end
            m_any   = 1'b0;
            e_last  = 1'b0;
            e_level = '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                // Samples two and more edges old have reached the counter.
                bit run_ok;
                run_ok = (m_valid[p] >= D + 1);
                for (int k = 1; k <= D; k++)
                    if (m_hist[p][k] == m_stable[p]) run_ok = 1'b0;
                if (run_ok) begin
                    if (m_stable[p]) e_release[p] = 1'b1;
                    else             e_press[p]   = 1'b1;
                    m_stable[p] = ~m_stable[p];
                end
                for (int k = D; k >= 1; k--) m_hist[p][k] = m_hist[p][k-1];
                m_hist[p][0] = r[p];
                if (m_valid[p] < D + 1) m_valid[p]++;
                e_level[p] = m_stable[p];
            end
            if (en_i) begin
                if (e_press == 2'b11) begin
                    e_conf = 1'b1;
                end else if (e_press != 2'b00) begin
                    logic pl;
                    pl = e_press[1];
                    if (!m_any || pl != e_last) begin
                        e_req[pl] = 1'b1;
                        e_last    = pl;
                        m_any     = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(raw, rst, en);
        #1;
        check("level",    o_level,     e_level);
        check("press",    o_press,     e_press);
        check("release",  o_release,   e_release);
        check("turn_req", o_turn_req,  e_req);
        check("conflict", o_conflict,  e_conf);
        check("last",     o_last_turn, e_last);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [1:0] acc;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        raw = 2'b00;
        run(2);
        check("rst_outputs", {o_level, o_press, o_release, o_turn_req, o_conflict, o_last_turn}, 10'd0);

        // 1: single press on P0
        rst = 1'b0;
        raw = 2'b01;
        run(5);
        check("t1_press_early", o_press, 2'b00);
        step();
        check("t1_press", o_press,     2'b01);
        check("t1_level", o_level,     2'b01);
        check("t1_req",   o_turn_req,  2'b01);
        check("t1_last",  o_last_turn, 1'b0);
        step();
        check("t1_pulses_low", {o_press, o_turn_req, o_conflict}, 5'd0);

        // 2: 3-cycle glitch on P1
        raw = 2'b11;
        acc = '0;
        for (int i = 0; i < 3; i++) begin step(); acc |= {o_level[1] | o_press[1], o_turn_req[1]}; end
        raw = 2'b01;
        for (int i = 0; i < 8; i++) begin step(); acc |= {o_level[1] | o_press[1], o_turn_req[1]}; end
        check("t2_glitch", acc, 2'b00);

        // 3: simultaneous press
        raw = 2'b00;
        run(8);
        raw = 2'b11;
        run(5);
        step();
        check("t3_conflict", o_conflict,  1'b1);
        check("t3_press",    o_press,     2'b11);
        check("t3_req",      o_turn_req,  2'b00);
        check("t3_last",     o_last_turn, 1'b0);
        step();
        check("t3_conflict_low", o_conflict, 1'b0);

        // 4: repeat P0 ignored, then P1 granted
        raw = 2'b00;
        run(8);
        raw = 2'b01;
        run(6);
        check("t4_press_p0", o_press,    2'b01);
        check("t4_req_p0",   o_turn_req, 2'b00);
        raw = 2'b00;
        run(8);
        raw = 2'b10;
        run(6);
        check("t4_req_p1",  o_turn_req,  2'b10);
        check("t4_last_p1", o_last_turn, 1'b1);

        // 5: masked press is dropped
        raw = 2'b00;
        run(8);
        en  = 1'b0;
        raw = 2'b01;
        run(6);
        check("t5_press", o_press,    2'b01);
        check("t5_req",   o_turn_req, 2'b00);
        en  = 1'b1;
        acc = '0;
        for (int i = 0; i < 8; i++) begin step(); acc |= o_turn_req; end
        check("t5_no_late_req", acc, 2'b00);

        // 6: reset mid-debounce
        raw = 2'b00;
        run(8);
        raw = 2'b01;
        run(4);
        rst = 1'b1;
        step();
        check("t6_rst_outputs", {o_level, o_press, o_release, o_turn_req, o_conflict, o_last_turn}, 10'd0);
        step();
        rst = 1'b0;
        run(5);
        check("t6_press_early", o_press, 2'b00);
        step();
        check("t6_press", o_press, 2'b01);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) raw[0] = ~raw[0];
            if ($urandom_range(5) == 0) raw[1] = ~raw[1];
            if ($urandom_range(40) == 0) en = ~en;
            rst = ($urandom_range(400) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
